// File: rtl/bloom_filter_engine.sv
// Bloom filter responder for the custom-op interface: insert/check/clear over valid/ready,
// bit array held in flops, one hash index evaluated per cycle, single-cycle response pulse.
module bloom_filter_engine #(
  parameter int DATA_W        = 32,
  parameter int IDX_W         = 8,
  parameter int NUM_HASH      = 2,
  parameter int CLR_PER_CYCLE = 32
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              resp_valid_o,
  output logic              resp_match_o,
  output logic              busy_o,
  output logic [IDX_W:0]    fill_cnt_o
);

  localparam int M_BITS = 1 << IDX_W;
  localparam int NSLICE = DATA_W / IDX_W;
  localparam int NCHUNK = M_BITS / CLR_PER_CYCLE;
  localparam int KW     = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1;
  localparam int PW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] OP_INS = 2'b01;
  localparam logic [1:0] OP_CHK = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_HASH, S_CLEAR, S_RESP} state_e;

  state_e            state_q;
  logic [M_BITS-1:0] bits_q;
  logic [DATA_W-1:0] key_q;
  logic [1:0]        op_q;
  logic              acc_q;
  logic [KW-1:0]     k_q;
  logic [PW-1:0]     ptr_q;
  logic [IDX_W:0]    fill_q;
  logic              resp_valid_q;
  logic              resp_match_q;

  logic [IDX_W-1:0]  fold;
  logic [IDX_W-1:0]  h_rot;
  logic [IDX_W-1:0]  h_salt;
  logic [IDX_W-1:0]  h_cur;
  logic              rd;

  // Rotate-left is taken from the doubled fold: shifting {f,f} right by (W-r)
  // leaves rotl(f,r) in the low W bits, which also covers r=0 without a special case.
  always_comb begin
    fold = '0;
    for (int s = 0; s < NSLICE; s++) fold = fold ^ key_q[s*IDX_W +: IDX_W];
    h_rot  = IDX_W'({fold, fold} >> (IDX_W - (int'(k_q) % IDX_W)));
    h_salt = IDX_W'(32'(k_q) * 32'h3B);
    h_cur  = h_rot ^ h_salt;
    rd     = bits_q[h_cur];
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      bits_q       <= '0;
      key_q        <= '0;
      op_q         <= '0;
      acc_q        <= 1'b0;
      k_q          <= '0;
      ptr_q        <= '0;
      fill_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_match_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_match_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            key_q <= req_data_i;
            op_q  <= req_op_i;
            acc_q <= 1'b1;
            k_q   <= '0;
            ptr_q <= '0;
            case (req_op_i)
              OP_INS, OP_CHK: state_q <= S_HASH;
              OP_CLR: begin
                state_q <= S_CLEAR;
                fill_q  <= '0;
              end
              default: begin
                state_q      <= S_RESP;
                resp_valid_q <= 1'b1;
              end
            endcase
          end
        end
        S_HASH: begin
          acc_q <= acc_q & rd;
          // A bit already set (possibly by an earlier index of this same key) is not recounted.
          if (op_q == OP_INS && !rd) begin
            bits_q[h_cur] <= 1'b1;
            fill_q        <= fill_q + (IDX_W+1)'(1);
          end
          if (k_q == KW'(NUM_HASH-1)) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_match_q <= acc_q & rd;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        S_CLEAR: begin
          bits_q[int'(ptr_q)*CLR_PER_CYCLE +: CLR_PER_CYCLE] <= '0;
          if (ptr_q == PW'(NCHUNK-1)) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
          end else begin
            ptr_q <= ptr_q + PW'(1);
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_match_o = resp_match_q;
  assign fill_cnt_o   = fill_q;

endmodule

// File: tb/tb_bloom_filter_engine.sv
// Directed bench for bloom_filter_engine with hand-computed hash indices and latencies.
module tb_bloom_filter_engine;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_INS = 2'b01;
  localparam logic [1:0] OP_CHK = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic        clk;
  logic        rst_ni;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic        resp_valid;
  logic        resp_match;
  logic        busy;
  logic [8:0]  fill_cnt;

  int n_chk;
  int n_fail;

  bloom_filter_engine #(
    .DATA_W(32), .IDX_W(8), .NUM_HASH(2), .CLR_PER_CYCLE(32)
  ) dut (
    .clk          (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_data_i   (req_data),
    .resp_valid_o (resp_valid),
    .resp_match_o (resp_match),
    .busy_o       (busy),
    .fill_cnt_o   (fill_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one command from IDLE; lat is the cycle (1 = first after acceptance) of the pulse.
  task automatic issue(input logic [1:0] op, input logic [31:0] key,
                       output int lat, output logic m);
    int w;
    lat = -1;
    m   = 1'b0;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("issue_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = key;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = OP_NOP;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = n;
        m   = resp_match;
        break;
      end
    end
    if (lat < 0) chk("resp_timeout", 32'd0, 32'd1);
    else begin
      @(negedge clk);
      chk("pulse_width", 32'(resp_valid), 32'd0);
    end
  endtask

  int          lat;
  logic        m;
  logic        take;
  int          n_acc, n_resp, last, n_pulse;
  logic [31:0] keys5 [3];

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_ni    = 1'b0;
    req_valid = 1'b0;
    req_op    = OP_NOP;
    req_data  = '0;
    keys5[0]  = 32'h40;
    keys5[1]  = 32'h41;
    keys5[2]  = 32'h42;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_match", 32'(resp_match), 32'd0);
    chk("rst_fill", 32'(fill_cnt), 32'd0);
    rst_ni = 1'b1;

    // Key 0x12: h0=0x12, h1=rotl(0x12,1)^0x3B=0x24^0x3B=0x1F
    issue(OP_CHK, 32'h12, lat, m);
    chk("t1_lat", 32'(lat), 32'd3);
    chk("t1_match", 32'(m), 32'd0);
    chk("t1_fill", 32'(fill_cnt), 32'd0);

    issue(OP_INS, 32'h12, lat, m);
    chk("t2_lat", 32'(lat), 32'd3);
    chk("t2_match", 32'(m), 32'd0);
    chk("t2_fill", 32'(fill_cnt), 32'd2);
    issue(OP_INS, 32'h12, lat, m);
    chk("t2b_match", 32'(m), 32'd1);
    chk("t2b_fill", 32'(fill_cnt), 32'd2);

    issue(OP_CHK, 32'h12, lat, m);
    chk("t3_match_hit", 32'(m), 32'd1);
    // Key 0x13: h0=0x13 (unset), h1=0x26^0x3B=0x1D
    issue(OP_CHK, 32'h13, lat, m);
    chk("t3_lat_miss", 32'(lat), 32'd3);
    chk("t3_match_miss", 32'(m), 32'd0);
    chk("t3_fill", 32'(fill_cnt), 32'd2);

    issue(OP_NOP, 32'hFFFF_FFFF, lat, m);
    chk("nop_lat", 32'(lat), 32'd1);
    chk("nop_match", 32'(m), 32'd0);

    issue(OP_INS, 32'h12, lat, m);
    chk("t4_ins_match", 32'(m), 32'd1);
    issue(OP_CLR, 32'h12, lat, m);
    chk("t4_clr_lat", 32'(lat), 32'd9);
    chk("t4_clr_match", 32'(m), 32'd0);
    chk("t4_clr_fill", 32'(fill_cnt), 32'd0);
    issue(OP_CHK, 32'h12, lat, m);
    chk("t4_chk_after_clr", 32'(m), 32'd0);

    // Back-to-back inserts with valid held high; indices 40/BB, 41/B9, 42/BF are disjoint.
    @(negedge clk);
    req_op    = OP_INS;
    req_data  = keys5[0];
    req_valid = 1'b1;
    n_acc  = 0;
    n_resp = 0;
    last   = 0;
    for (int c = 0; c < 60 && n_resp < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (resp_valid) n_resp++;
      take = req_valid && req_ready;
      if (take) begin
        if (n_acc > 0) chk("t5_spacing", 32'(c - last), 32'd4);
        last = c;
        n_acc++;
      end
      @(posedge clk);
      #1;
      if (take) begin
        if (n_acc == 3) req_valid = 1'b0;
        else            req_data  = keys5[n_acc];
      end
    end
    req_valid = 1'b0;
    chk("t5_accepts", 32'(n_acc), 32'd3);
    chk("t5_resps", 32'(n_resp), 32'd3);
    chk("t5_fill", 32'(fill_cnt), 32'd6);
    for (int i = 0; i < 3; i++) begin
      issue(OP_CHK, keys5[i], lat, m);
      chk($sformatf("t5_present_%0d", i), 32'(m), 32'd1);
    end

    // Key 0x55: h0=0x55, h1=0xAA^0x3B=0x91; reset lands after the first index is written.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_INS;
    req_data  = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = OP_NOP;
    @(posedge clk);
    #2;
    chk("t6_fill_mid", 32'(fill_cnt), 32'd7);
    chk("t6_busy_mid", 32'(busy), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("t6_async_ready", 32'(req_ready), 32'd1);
    chk("t6_async_busy", 32'(busy), 32'd0);
    chk("t6_async_fill", 32'(fill_cnt), 32'd0);
    n_pulse = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) n_pulse++;
    end
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) n_pulse++;
    end
    chk("t6_no_pulse", 32'(n_pulse), 32'd0);
    issue(OP_CHK, 32'h55, lat, m);
    chk("t6_55_cleared", 32'(m), 32'd0);
    issue(OP_CHK, 32'h40, lat, m);
    chk("t6_40_cleared", 32'(m), 32'd0);
    chk("t6_fill_end", 32'(fill_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
